// File: rtl/axi_stream_packer_pkg.sv
// Shared widths and the FIFO entry layout for the AXI-stream byte packer.
// The entry bundles the packed word with its byte count and end-of-packet flag.
package axi_stream_packer_pkg;

  localparam int AXIS_DATA_W    = 8;
  localparam int WORD_W         = 64;
  localparam int BYTES_PER_WORD = 8;
  localparam int CNT_FIELD_W    = 4;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);

  typedef struct packed {
    logic                   pkt_end;
    logic [CNT_FIELD_W-1:0] cnt;
    logic [WORD_W-1:0]      data;
  } word_entry_t;

  localparam int ENTRY_W = $bits(word_entry_t);

endpackage

// File: rtl/axis_sync_fifo.sv
// Show-ahead synchronous FIFO; the head entry is always presented on rd_data_o.
// Full/empty come from an explicit level counter so pointers can wrap freely.
module axis_sync_fifo
  import axi_stream_packer_pkg::*;
#(
  parameter int WIDTH = ENTRY_W,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH),
  localparam int LW   = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [LW-1:0]    level_next_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic [LW-1:0]    level_d;
  logic             do_wr;
  logic             do_rd;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign do_wr   = wr_en_i & ~full_o;
  assign do_rd   = rd_en_i & ~empty_o;
  assign level_d = level_q + LW'(do_wr) - LW'(do_rd);

  // Next-state level lets the consumer register a ready that is never stale.
  assign level_next_o = level_d;

  // Empty head reads as zero so stale storage never leaks onto the outputs.
  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      level_q <= level_d;
      if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/axi_stream_packer.sv
// AXI-stream byte sink: packs bytes little-endian into 64-bit words, queues them
// in a show-ahead FIFO and counts completed packets.
module axi_stream_packer
  import axi_stream_packer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [AXIS_DATA_W-1:0] data,
  input  logic                   valid,
  input  logic                   last,
  output logic                   ready,
  output logic [WORD_W-1:0]      out_data,
  output logic [CNT_FIELD_W-1:0] out_cnt,
  output logic                   out_end,
  output logic                   out_valid,
  input  logic                   out_re,
  output logic [CNT_W-1:0]       pkt_cnt,
  output logic                   overflow
);

  localparam int LW = $clog2(DEPTH) + 1;

  logic [WORD_W-1:0] acc_q;
  logic [WORD_W-1:0] acc_d;
  logic [WORD_W-1:0] word_d;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_d;
  logic              ready_q;
  logic              overflow_q;
  logic [CNT_W-1:0]  pkt_cnt_q;
  logic              xfer;
  logic              complete;
  word_entry_t       push_entry;
  word_entry_t       head_entry;
  logic              fifo_full;
  logic              fifo_empty;
  logic [LW-1:0]     fifo_level_d;

  assign xfer = valid & ready_q;

  always_comb begin
    word_d = acc_q;
    word_d[AXIS_DATA_W*idx_q +: AXIS_DATA_W] = data;
    complete = xfer & (last | (idx_q == IDX_W'(BYTES_PER_WORD - 1)));
    acc_d = acc_q;
    idx_d = idx_q;
    if (xfer) begin
      if (complete) begin
        acc_d = '0;
        idx_d = '0;
      end else begin
        acc_d = word_d;
        idx_d = idx_q + 1'b1;
      end
    end
    push_entry.pkt_end = last;
    push_entry.cnt     = CNT_FIELD_W'(idx_q) + CNT_FIELD_W'(1);
    push_entry.data    = word_d;
  end

  axis_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst_n        (reset_n),
    .wr_en_i      (complete),
    .wr_data_i    (push_entry),
    .rd_en_i      (out_re),
    .rd_data_o    (head_entry),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .level_next_o (fifo_level_d)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q      <= '0;
      idx_q      <= '0;
      ready_q    <= 1'b0;
      overflow_q <= 1'b0;
      pkt_cnt_q  <= '0;
    end else begin
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      ready_q <= (fifo_level_d != LW'(DEPTH));
      // A push into a full FIFO is dropped; only a ready violation gets here.
      if (complete && fifo_full) overflow_q <= 1'b1;
      if (complete && last && !fifo_full) pkt_cnt_q <= pkt_cnt_q + 1'b1;
    end
  end

  assign ready     = ready_q;
  assign out_data  = head_entry.data;
  assign out_cnt   = head_entry.cnt;
  assign out_end   = head_entry.pkt_end;
  assign out_valid = ~fifo_empty;
  assign pkt_cnt   = pkt_cnt_q;
  assign overflow  = overflow_q;

endmodule
